// File: rtl/mem_write_checker.sv
// mem_write_checker: sticky registered PASS/FAIL verdict from watching the CPU data-memory write port
module mem_write_checker #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] PASS_ADDR = 84,
  parameter logic [DATA_W-1:0] PASS_DATA = 7,
  parameter logic [ADDR_W-1:0] ALLOW_ADDR = 80,
  parameter bit STRICT = 1,
  parameter int TIMEOUT = 10000,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] dataAdr,
  input  logic [DATA_W-1:0] writeData,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        failCode,
  output logic [CNT_W-1:0]  writeCount,
  output logic [ADDR_W-1:0] lastAdr,
  output logic [DATA_W-1:0] lastData
);
  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL} state_t;
  localparam logic [CNT_W-1:0] TLIM = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] cyc, cyc_n;
  logic [1:0] code_n;
  logic we, at_pass, good, illegal, tmo;
  always_ff @(posedge clk)
    state <= rst ? S_RUN : state_n;
  always_comb begin
    we      = memWrite && state == S_RUN;
    at_pass = dataAdr == PASS_ADDR;
    good    = writeData == PASS_DATA;
    illegal = STRICT && !at_pass && dataAdr != ALLOW_ADDR;
    tmo     = state == S_RUN && TIMEOUT != 0 && cyc == TLIM;
    state_n = state != S_RUN ? state :
              we && at_pass ? (good ? S_PASS : S_FAIL) :
              (we && illegal) || tmo ? S_FAIL : S_RUN;
    code_n  = state != S_RUN ? failCode :
              we && at_pass ? (good ? 2'd0 : 2'd2) :
              we && illegal ? 2'd1 : tmo ? 2'd3 : 2'd0;
    cyc_n   = state == S_RUN && cyc != TLIM ? cyc + CNT_W'(1) : cyc;
  end
  always_comb begin
    pass = state == S_PASS;
    fail = state == S_FAIL;
    done = pass || fail;
  end
  always_ff @(posedge clk)
    if (rst) begin
      cyc        <= '0;
      failCode   <= '0;
      writeCount <= '0;
      lastAdr    <= '0;
      lastData   <= '0;
    end else begin
      cyc      <= cyc_n;
      failCode <= code_n;
      if (we) begin
        writeCount <= writeCount + CNT_W'(writeCount != '1);
        lastAdr    <= dataAdr;
        lastData   <= writeData;
      end
    end
endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: four parameter variants driven in lockstep and compared against a spec-level model
module tb_mem_write_checker;
  logic clk = 0;
  logic rst = 1;
  logic memWrite = 0;
  logic [31:0] dataAdr = 0;
  logic [31:0] writeData = 0;
  logic d[4], p[4], f[4];
  logic [1:0] fc[4];
  logic [15:0] wcx[4];
  logic [1:0] wc3;
  logic [31:0] la[4], ld[4];
  int total = 0;
  int passed = 0;
  typedef struct {
    bit done;
    bit pass;
    int code;
    int cnt;
    int cyc;
    logic [31:0] adr;
    logic [31:0] data;
  } m_t;
  m_t m[4];
  int strict_p[4] = '{1, 0, 1, 0};
  int tmo_p[4] = '{10000, 10000, 20, 0};
  int cmax_p[4] = '{65535, 65535, 65535, 3};
  always #5 clk = ~clk;
  assign wcx[3] = {14'b0, wc3};
  mem_write_checker u0 (.clk(clk), .rst(rst), .memWrite(memWrite), .dataAdr(dataAdr), .writeData(writeData),
    .done(d[0]), .pass(p[0]), .fail(f[0]), .failCode(fc[0]), .writeCount(wcx[0]), .lastAdr(la[0]), .lastData(ld[0]));
  mem_write_checker #(.STRICT(0)) u1 (.clk(clk), .rst(rst), .memWrite(memWrite), .dataAdr(dataAdr), .writeData(writeData),
    .done(d[1]), .pass(p[1]), .fail(f[1]), .failCode(fc[1]), .writeCount(wcx[1]), .lastAdr(la[1]), .lastData(ld[1]));
  mem_write_checker #(.TIMEOUT(20)) u2 (.clk(clk), .rst(rst), .memWrite(memWrite), .dataAdr(dataAdr), .writeData(writeData),
    .done(d[2]), .pass(p[2]), .fail(f[2]), .failCode(fc[2]), .writeCount(wcx[2]), .lastAdr(la[2]), .lastData(ld[2]));
  mem_write_checker #(.STRICT(0), .TIMEOUT(0), .CNT_W(2)) u3 (.clk(clk), .rst(rst), .memWrite(memWrite), .dataAdr(dataAdr), .writeData(writeData),
    .done(d[3]), .pass(p[3]), .fail(f[3]), .failCode(fc[3]), .writeCount(wc3), .lastAdr(la[3]), .lastData(ld[3]));
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, o, e);
  endtask
  task automatic model(input int i, input logic r, input logic w, input logic [31:0] a, input logic [31:0] dt);
    if (r) begin
      m[i] = '{0, 0, 0, 0, 0, 32'h0, 32'h0};
      return;
    end
    if (m[i].done) return;
    m[i].cyc++;
    if (w) begin
      m[i].cnt = m[i].cnt < cmax_p[i] ? m[i].cnt + 1 : m[i].cnt;
      m[i].adr = a;
      m[i].data = dt;
      if (a == 84) begin
        m[i].done = 1;
        m[i].pass = dt == 7;
        m[i].code = dt == 7 ? 0 : 2;
      end else if (a != 80 && strict_p[i] != 0) begin
        m[i].done = 1;
        m[i].code = 1;
      end
    end
    if (!m[i].done && tmo_p[i] != 0 && m[i].cyc == tmo_p[i]) begin
      m[i].done = 1;
      m[i].code = 3;
    end
  endtask
  task automatic check_inst(input int i);
    chk($sformatf("u%0d.done", i), 64'(d[i]), 64'(m[i].done));
    chk($sformatf("u%0d.pass", i), 64'(p[i]), 64'(m[i].pass));
    chk($sformatf("u%0d.fail", i), 64'(f[i]), 64'(m[i].done && !m[i].pass));
    chk($sformatf("u%0d.failCode", i), 64'(fc[i]), 64'(m[i].code));
    chk($sformatf("u%0d.writeCount", i), 64'(wcx[i]), 64'(m[i].cnt));
    chk($sformatf("u%0d.lastAdr", i), 64'(la[i]), 64'(m[i].adr));
    chk($sformatf("u%0d.lastData", i), 64'(ld[i]), 64'(m[i].data));
  endtask
  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] dt);
    rst = r;
    memWrite = w;
    dataAdr = a;
    writeData = dt;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) model(i, r, w, a, dt);
    for (int i = 0; i < 4; i++) check_inst(i);
  endtask
  initial begin
    logic [31:0] a, dt;
    step(1, 0, 0, 0);
    step(1, 1, 84, 7);
    step(0, 1, 80, 3);
    step(0, 1, 84, 7);
    chk("plan.pass_count", 64'(wcx[0]), 64'd2);
    step(0, 1, 96, 1);
    chk("plan.pass_sticky", 64'(p[0]), 64'd1);
    step(1, 0, 0, 0);
    step(0, 1, 84, 6);
    chk("plan.bad_data_code", 64'(fc[0]), 64'd2);
    step(1, 0, 0, 0);
    step(0, 1, 96, 1);
    chk("plan.illegal_code", 64'(fc[0]), 64'd1);
    chk("plan.lax_count", 64'(wcx[1]), 64'd1);
    step(0, 1, 84, 7);
    chk("plan.lax_pass", 64'(p[1]), 64'd1);
    step(1, 0, 0, 0);
    for (int k = 1; k < 20; k++) step(0, 0, 0, 0);
    chk("plan.tmo_edge19", 64'(f[2]), 64'd0);
    step(0, 0, 0, 0);
    chk("plan.tmo_edge20", 64'({f[2], fc[2]}), 64'b111);
    step(1, 0, 0, 0);
    for (int k = 1; k < 20; k++) step(0, 0, 0, 0);
    step(0, 1, 84, 7);
    chk("plan.tmo_tie_pass", 64'({p[2], f[2]}), 64'b10);
    step(1, 0, 0, 0);
    step(0, 1, 80, 1);
    step(0, 1, 80, 1);
    step(1, 0, 0, 0);
    step(0, 1, 84, 7);
    chk("plan.rst_midrun_count", 64'(wcx[0]), 64'd1);
    step(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 96, 32'(k));
    chk("plan.sat_count", 64'(wc3), 64'd3);
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 3))
        0: a = 80;
        1: a = 84;
        2: a = 96;
        default: a = $urandom;
      endcase
      dt = $urandom_range(0, 1) != 0 ? 32'd7 : 32'($urandom_range(0, 9));
      step(logic'($urandom_range(0, 11) == 0), logic'($urandom_range(0, 2) != 0), a, dt);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesizable, parametrised pass/fail monitor for the CPU data-memory write port. It sits beside `top` in simulation benches or on an FPGA build with LEDs. It watches `memWrite`/`dataAdr`/`writeData` every rising clock edge and decides PASS when the programmed signature write occurs. It decides FAIL on an illegal write, a wrong signature value, or a cycle timeout. The verdict is sticky and registered, so benches and hardware use the same check.

## Interface
Parameters:
- `ADDR_W`, 32, width of `dataAdr`.
- `DATA_W`, 32, width of `writeData`.
- `PASS_ADDR`, 84, signature address; a write here decides the run.
- `PASS_DATA`, 7, required signature value.
- `ALLOW_ADDR`, 80, the one non-signature address always legal to write.
- `STRICT`, 1, 1: a write to any other address is FAIL; 0: such writes are counted only.
- `TIMEOUT`, 10000, RUN cycles before timeout FAIL; 0 disables the timeout.
- `CNT_W`, 16, width of the cycle and write counters.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `memWrite`  in  1  write strobe from the CPU.
- `dataAdr`  in  ADDR_W  write address.
- `writeData`  in  DATA_W  write data.
- `done`  out  1  verdict reached (PASS or FAIL).
- `pass`  out  1  verdict is PASS.
- `fail`  out  1  verdict is FAIL.
- `failCode`  out  2  0 none, 1 illegal address, 2 bad signature data, 3 timeout.
- `writeCount`  out  CNT_W  number of writes sampled in RUN, saturating.
- `lastAdr`  out  ADDR_W  address of the most recent sampled write.
- `lastData`  out  DATA_W  data of the most recent sampled write.

## Operation
- FSM has three states: RUN, PASS, FAIL. Reset enters RUN.
- RUN, on an edge with `memWrite`=1:
  - `dataAdr`==PASS_ADDR and `writeData`==PASS_DATA: go to PASS.
  - `dataAdr`==PASS_ADDR and data differs: go to FAIL with code 2.
  - `dataAdr`==ALLOW_ADDR: stay in RUN.
  - Any other address: if STRICT=1, go to FAIL with code 1; if STRICT=0, stay in RUN.
  - Every sampled write increments `writeCount` and updates `lastAdr`/`lastData`, including the deciding write.
- Cycle counter: counts every RUN edge. If TIMEOUT≠0 and the counter reaches TIMEOUT-1 on an edge with no deciding write, go to FAIL with code 3.
- Simultaneous events: a deciding write on the timeout edge wins. PASS is not overridden by timeout.
- If PASS_ADDR==ALLOW_ADDR, the PASS_ADDR rules take precedence.
- PASS and FAIL are terminal and sticky. In these states, writes are ignored: no count, `last*` are frozen, and `failCode` is held. Only `rst` leaves them.
- `writeCount` saturates at 2^CNT_W-1. The cycle counter stops at TIMEOUT-1.
- X/Z on the inputs is not handled; the bench is responsible for driving known values.

## Timing
- All outputs are registered. Reset values: `done`=0, `pass`=0, `fail`=0, `failCode`=0, `writeCount`=0, `lastAdr`=0, `lastData`=0. Internal state is RUN, cycle counter 0.
- Verdict latency is one cycle. The edge that samples the deciding write updates `done`/`pass`/`fail`/`failCode`, so they are visible immediately after that edge.
- `done` = `pass` | `fail` at all times. `pass` and `fail` are never both 1.
- Timeout: with no deciding write, `fail` rises after exactly TIMEOUT RUN edges following reset deassertion.
- `rst` asserted in any state, including mid-run, clears everything on the next edge. A write on a reset edge is not sampled.

## Test plan
- Write 80←3, then 84←7 (STRICT=1) -> after the second edge: `pass`=1, `done`=1, `failCode`=0, `writeCount`=2, `lastAdr`=84, `lastData`=7. A later write 96←1 leaves all outputs unchanged.
- Write 84←6 -> `fail`=1, `failCode`=2, `lastData`=6.
- STRICT=1, write 96←1 -> `fail`=1, `failCode`=1. Same stimulus with STRICT=0 -> no verdict, `writeCount`=1; a following write 84←7 gives `pass`=1.
- TIMEOUT=20, no writes -> `fail` low through edge 19 and high after edge 20, `failCode`=3. Variant: 84←7 sampled on edge 20 -> `pass`=1, not fail.
- Reset mid-run: write 80←1 twice, then `rst`=1 for one edge -> all outputs 0, counter restarted. Then 84←7 gives `pass` with `writeCount`=1.
- CNT_W=2, STRICT=0: five writes to 96 -> `writeCount` saturates at 3.
